sbox: RTL and testbench

SBOX -- requirements
Module: sbox

---
 rtl/aes_pkg.sv | 33 +++
 rtl/sbox_byte.sv | 16 +
 rtl/sbox.sv | 40 ++++
 tb/tb_sbox.sv | 137 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg: AES byte/state widths and the FIPS-197 forward S-box table.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int c_BYTE_W  = 8;
  localparam int c_STATE_W = 128;
  localparam int c_NBYTES  = c_STATE_W / c_BYTE_W;

  // Entry n holds S(n); rows are 16 consecutive inputs starting at 0x00.
  localparam logic [c_BYTE_W-1:0] c_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage : aes_pkg
`default_nettype wire

// File: rtl/sbox_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbox_byte: combinational single-byte AES forward S-box lookup.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sbox_byte
  import aes_pkg::*;
(
  input  logic [c_BYTE_W-1:0] a_i,
  output logic [c_BYTE_W-1:0] y_o
);

  assign y_o = c_SBOX[a_i];

endmodule : sbox_byte
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sbox: 16-lane AES SubBytes with a single registered 128-bit output.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sbox
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [c_STATE_W-1:0] s_in,
  output logic [c_STATE_W-1:0] s_o
);

  logic [c_STATE_W-1:0] w_sub;
  logic [c_STATE_W-1:0] s_d;
  logic [c_STATE_W-1:0] s_q;

  // Lanes stay in place: byte i in feeds byte i out, no reordering.
  for (genvar i = 0; i < c_NBYTES; i++) begin : g_lane
    sbox_byte u_sbox_byte (
      .a_i (s_in [i*c_BYTE_W +: c_BYTE_W]),
      .y_o (w_sub[i*c_BYTE_W +: c_BYTE_W])
    );
  end

  assign s_d = w_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s_o = s_q;

endmodule : sbox
`default_nettype wire

// File: tb/tb_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sbox: self-checking bench; S-box reference built from GF(2^8).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sbox;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_in;
  logic [127:0] s_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ref_tab [256];

  sbox dut (
    .clk  (clk),
    .rst  (rst),
    .s_in (s_in),
    .s_o  (s_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_tab[v[i*8 +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle model: output after an edge is S(input) or zero under reset.
  logic [127:0] exp_q;
  bit           have_exp = 1'b0;
  always @(posedge clk) begin
    exp_q    = rst ? 128'h0 : sub_state(s_in);
    have_exp = 1'b1;
    #1;
    if (have_exp) check("stream", s_o, exp_q);
  end

  task automatic apply(input logic [127:0] v, input logic r);
    @(negedge clk);
    s_in = v;
    rst  = r;
  endtask

  task automatic expect_lit(input string name, input logic [127:0] exp);
    @(posedge clk);
    #1;
    check(name, s_o, exp);
  endtask

  initial begin
    logic [127:0] v;
    for (int n = 0; n < 256; n++) ref_tab[n] = sbox_ref(8'(n));

    check("model_S00", {120'h0, ref_tab[8'h00]}, 128'h63);
    check("model_S01", {120'h0, ref_tab[8'h01]}, 128'h7c);
    check("model_S53", {120'h0, ref_tab[8'h53]}, 128'hed);
    check("model_Sff", {120'h0, ref_tab[8'hff]}, 128'h16);

    rst  = 1'b1;
    s_in = 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
    expect_lit("reset_first_edge", 128'h0);
    apply(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1);
    expect_lit("reset_second_edge", 128'h0);

    apply(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b0);
    expect_lit("fips_vector", 128'h6382_93c3_1bfc_33f5_c4ee_acea_4bc1_2816);

    // Mid-cycle input change and reset assertion must not reach the output.
    #2;
    s_in = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
    rst  = 1'b1;
    #1;
    check("hold_between_edges", s_o, 128'h6382_93c3_1bfc_33f5_c4ee_acea_4bc1_2816);

    apply(128'h0, 1'b0);
    expect_lit("zero_input", {16{8'h63}});
    apply({16{8'hff}}, 1'b0);
    expect_lit("all_ff", {16{8'h16}});
    apply({16{8'h53}}, 1'b0);
    expect_lit("all_53", {16{8'hed}});

    // Back-to-back stream with a single-cycle reset in the middle.
    for (int j = 0; j < 40; j++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      apply(v, (j == 20));
    end
    expect_lit("after_midstream", sub_state(v));

    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'((k + i) % 256);
      apply(v, 1'b0);
    end

    apply(128'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sbox
`default_nettype wire
